// File: rtl/arbiter_4_rr.sv
// rtl/arbiter_4_rr.sv - four-way round-robin arbiter with bounded grant hold
//
// Ports:
//   clk          system clock, posedge
//   Reset        synchronous active-high reset
//   EN           enables issuing of new grants (never revokes an active one)
//   CLR          synchronous clear of pointer, hold counter and grant
//   req[3:0]     level requests, bit i belongs to requester i
//   lock         extends the current grant past MAX_HOLD (ARB_LOCK_EN only)
//   grant[3:0]   one-hot grant, zero when idle
//   grant_idx    index of the granted (or last granted) requester
//   grant_valid  high while a grant is active
//   timeout      one-cycle pulse when a grant is revoked by MAX_HOLD
//   wrap         one-cycle pulse when the priority pointer moves from 3 to 0
//
// Optional feature macro: ARB_LOCK_EN (lock suppresses the forced release).
module arbiter_4_rr #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       EN,
  input  logic       CLR,
  input  logic [3:0] req,
  input  logic       lock,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout,
  output logic       wrap
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
  logic              wrap_q, wrap_d;

  logic              sel_found;
  logic [1:0]        sel_idx;
  logic              lock_hold;
  logic              at_max;
  logic              rel_normal;

`ifdef ARB_LOCK_EN
  assign lock_hold = lock & req[idx_q];
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign lock_hold   = 1'b0;
`endif

  // First set request starting at ptr and walking upward modulo 4.
  always_comb begin
    logic [1:0] cand;
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign at_max     = (hold_q == HOLD_LAST);
  assign rel_normal = ~req[idx_q];

  // State register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      idx_q     <= 2'd0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      wrap_q    <= wrap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    wrap_d    = 1'b0;
    if (CLR) begin
      state_d = IDLE;
      ptr_d   = 2'd0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (EN && sel_found) begin
            state_d = GRANT;
            idx_d   = sel_idx;
            hold_d  = '0;
          end
        end
        GRANT: begin
          if (rel_normal || (at_max && !lock_hold)) begin
            state_d   = IDLE;
            ptr_d     = idx_q + 2'd1;
            timeout_d = ~rel_normal;
            wrap_d    = (ptr_q == 2'd3) && (idx_q == 2'd3);
          end else begin
            // Saturates only when lock keeps the grant alive at the limit.
            hold_d = at_max ? hold_q : hold_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    grant       = (state_q == GRANT) ? (4'b0001 << idx_q) : 4'b0000;
    grant_valid = (state_q == GRANT);
    grant_idx   = idx_q;
    timeout     = timeout_q;
    wrap        = wrap_q;
  end

endmodule

// File: doc/arbiter_4_rr.md
Name: arbiter_4_rr

Overview:
- Round-robin arbiter and scheduler for a shared 4-way resource, indexed by a 2-bit counter and decoded 4-to-2 / 2-to-4.
- Accepts four level requests and grants exactly one requester at a time.
- Outputs both a one-hot grant and a 2-bit grant index, so the index can drive the existing coder path directly.
- Bounds each grant with a hold timer, guaranteeing fairness.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held; legal range 1..2^HOLD_W.
- HOLD_W, 4, width of the internal hold counter.

Ports:
- clk  input  1  system clock.
- Reset  input  1  reset, synchronous, active-high.
- EN  input  1  enables issuing of new grants.
- CLR  input  1  synchronous clear of the arbitration state.
- req  input  4  level requests; bit i belongs to requester i.
- lock  input  1  holds the current grant past MAX_HOLD (ARB_LOCK_EN only).
- grant  output  4  one-hot grant; all zero when nothing is granted.
- grant_idx  output  2  index of the granted requester.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
- wrap  output  1  one-cycle pulse when the priority pointer wraps from 3 to 0.

Behaviour:
- Clock and reset:
  - All logic is clocked on the posedge of clk.
  - Reset is synchronous and active-high; it has no effect between edges.
- Reset values:
  - Outputs: grant=0, grant_idx=0, grant_valid=0, timeout=0, wrap=0.
  - Internal: ptr=0, hold_cnt=0, state=IDLE.
- State IDLE:
  - At an edge where EN=1 and req!=0, select the first requester with req set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On that edge: grant[sel]=1, grant_idx=sel, grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency is one cycle from a sampled req to a visible grant.
  - With EN=0 or req=0, remain in IDLE with all outputs zero.
- State GRANT:
  - At each edge, hold_cnt increments.
  - Release when req[grant_idx]=0 (normal release) or hold_cnt==MAX_HOLD-1 (forced release).
  - Otherwise the grant holds.
  - A requester holding req high continuously receives exactly MAX_HOLD grant cycles.
  - EN=0 does not revoke an active grant; it only blocks new grants.
- Release (registered on the release edge):
  - grant=0, grant_valid=0, grant_idx keeps its last value, state=IDLE.
  - ptr = grant_idx+1, with 2-bit wrap.
  - timeout=1 for one cycle if the release was forced.
  - wrap=1 for one cycle if ptr changes from 3 to 0.
- Turnaround: a minimum of one idle cycle (grant=0) always separates consecutive grants.
- Requests changing in other bits during GRANT have no effect until the next IDLE arbitration.
- CLR:
  - At an edge with CLR=1 and Reset=0: grant=0, grant_valid=0, ptr=0, hold_cnt=0, state=IDLE.
  - timeout and wrap are 0 on that edge.
  - Reset has priority over CLR; CLR has priority over arbitration and release.
- MAX_HOLD=1: every grant lasts one cycle, and timeout pulses whenever the request is still high at release.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - While in GRANT with lock=1 and req[grant_idx]=1, the forced release is suppressed.
  - hold_cnt saturates at MAX_HOLD-1.
  - Releasing lock with the counter saturated forces release on the next edge, with a timeout pulse.
- Undefined: lock is ignored, and the port remains for a fixed pinout.

Test Plan:
- Reset=1 for 3 edges with req=4'b1111, EN=1 -> grant=0, grant_valid=0; after Reset falls, grant=4'b0001 and grant_idx=0 one edge later.
- MAX_HOLD=4, req=4'b1111 held, EN=1 -> grant sequence 0001,0010,0100,1000,0001.
  - Each grant lasts 4 cycles, followed by 1 zero cycle.
  - timeout pulses after each grant.
  - wrap pulses once after the 1000 grant.
- ptr=0, req=4'b0100 -> grant_idx=2; drop req[2] after 2 cycles -> grant=0 next edge, timeout=0, then grant 4'b0001 when only req[0] is set and ptr=3.
- Mid-grant of index 1, pulse CLR one cycle -> grant=0 next edge, ptr=0; with req=4'b1010 the next grant goes to index 1.
- EN=0 during an active grant of index 2 -> grant held until req[2] drops; no further grant is issued while EN=0.
- ARB_LOCK_EN, MAX_HOLD=4, lock=1, req=4'b0001 for 10 cycles -> grant held for 10 cycles, no timeout; lock drops with req high -> release next edge, timeout=1.
